cfg_writer: RTL and testbench
=============================

# cfg_writer

Configuration-bus master for the controller's parameter registers. Receives a byte stream from the host UART receiver, parses framed write commands, verifies them, and drives the shared `addr` / `shift` / `en` register-write bus. Every addressed parameter block (predictor, pulse limiter, etc.) latches `shift` when `en` is high and `addr` matches its `ADDR`. Sits between the UART RX byte interface and all bus-attached blocks.

## Interface
- `DATA_MAX`, 255: largest legal parameter value. `DW = $clog2(DATA_MAX+1)`.
- `ADDR_MAX`, 4: highest legal register address. `AW = $clog2(ADDR_MAX+1)`.
- `TIMEOUT`, 50000: idle clocks allowed between bytes inside a frame.
- `clk`, in, 1: single system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `rx_data`, in, 8: received byte, synchronous to `clk`.
- `rx_valid`, in, 1: one-cycle strobe qualifying `rx_data`. No backpressure.
- `addr`, out, AW: register address on the write bus.
- `shift`, out, DW: write data on the write bus.
- `en`, out, 1: one-cycle write strobe.
- `err`, out, 1: one-cycle frame-rejected strobe.
- `err_code`, out, 2: reason for the last rejection, held until the next one. 1 = checksum, 2 = range, 3 = timeout.

## Operation
- Frame format: `SYNC` (0xA5), `ADDR` byte, then `NB = (DW+7)/8` data bytes (LSB first), then `CSUM`.
- `CSUM` = XOR of the `ADDR` byte and all data bytes. `SYNC` is excluded.
- FSM states:
  - IDLE: discard bytes until one equals 0xA5, then go to ADDR.
  - ADDR: store the byte, clear the byte counter, go to DATA.
  - DATA: shift bytes into an `8*NB` accumulator. After `NB` bytes go to CSUM.
  - CSUM: evaluate the frame and always return to IDLE.
- 0xA5 inside a frame is ordinary payload. There is no resynchronisation mid-frame.
- CSUM evaluation order:
  1. Checksum mismatch: `err_code=1`.
  2. Otherwise, `ADDR` byte > `ADDR_MAX`, or accumulator > `DATA_MAX`: `err_code=2`.
  3. Otherwise, write.
- Write: `addr <= ADDR[AW-1:0]`, `shift <= acc[DW-1:0]`, `en <= 1` for exactly one cycle.
- `addr` and `shift` hold their values until the next successful write.
- A rejected frame never changes `addr` or `shift` and never pulses `en`.
- Timeout: in any state other than IDLE, a counter increments each clock with no `rx_valid` and clears on `rx_valid`. When it reaches `TIMEOUT`: go to IDLE, pulse `err`, set `err_code=3`. The counter is held at 0 in IDLE.
- Reset values: `addr=0`, `shift=0`, `en=0`, `err=0`, `err_code=0`, state IDLE, accumulator and counters 0.
- Reset asserted mid-frame discards the partial frame. No write and no `err` are emitted.

## Timing
- `en` / `err` rise on the clock edge that samples the CSUM byte's `rx_valid`. Latency is 1 cycle from the CSUM strobe; both outputs are registered.
- `en` and `err` are never high in the same cycle.
- A byte with `rx_valid` in the cycle immediately after CSUM is processed by IDLE. Back-to-back frames are supported with zero gap.
- If `rx_valid` arrives on the same edge the timeout counter would reach `TIMEOUT`, the byte wins: the counter clears and there is no timeout.
- Timeout `err` pulses on the edge where the counter reaches `TIMEOUT`, i.e. `TIMEOUT` clocks after the last accepted byte.

## Structure
- Package `cfg_pkg`:
  - `SYNC_BYTE = 8'hA5`
  - state enum `{IDLE, ADDR, DATA, CSUM}`
  - err code enum `{ERR_NONE, ERR_CSUM, ERR_RANGE, ERR_TIMEOUT}`
- Sub-module `cfg_timer`: parameter `TIMEOUT`; inputs `clk`, `rst_n`, `run`, `kick`; output `expired`. This is the inter-byte timeout counter, width `$clog2(TIMEOUT+1)`.
- Top `cfg_writer` contains the FSM, accumulator, checksum register and output registers.

## Test plan
All scenarios use defaults unless stated (`NB=1`, `AW=3`).
- Single write: bytes A5 04 37 33 -> one-cycle `en`, `addr=4`, `shift=0x37`. Values hold afterwards; `err` stays 0.
- Bad checksum, then recovery: A5 02 10 13 -> `err`, `err_code=1`, no `en`. Next, A5 02 10 12 -> `en`, `addr=2`, `shift=0x10`.
- Range: A5 05 01 04 -> `err_code=2`. Separately with `DATA_MAX=1000`: A5 01 E9 03 EB (1001) -> `err_code=2`; A5 01 E8 03 EA -> `en`, `shift=1000`.
- Payload 0xA5 and back-to-back: noise 00 FF, then A5 03 A5 A6, then immediately A5 00 00 00 -> two `en` pulses (`addr=3`/`shift=0xA5`, then `addr=0`/`shift=0`), one cycle apart from their CSUM strobes.
- Timeout with `TIMEOUT=20`: A5 01, then silence -> `err`, `err_code=3` exactly 20 clocks after the 01 strobe. Edge case: a byte on clock 20 -> no timeout.
- Reset mid-frame: A5 01, assert `rst_n=0` asynchronously between clocks -> all outputs 0 immediately. After release, 7F 7E (a CSUM-like tail) -> no `en`, no `err`.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration-bus writer.
package cfg_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, CSUM} state_e;

  typedef enum logic [1:0] {ERR_NONE, ERR_CSUM, ERR_RANGE, ERR_TIMEOUT} err_code_e;

endpackage

// File: rtl/cfg_writer_if.sv
// Byte-stream input and register-write bus of the configuration writer.
interface cfg_writer_if #(
   parameter int unsigned AW = 3,
   parameter int unsigned DW = 8
);
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic [AW-1:0] addr;
   logic [DW-1:0] shift;
   logic          en;
   logic          err;
   logic [1:0]    err_code;

   modport master (
      input  rx_data, rx_valid,
      output addr, shift, en, err, err_code
   );

   modport slave (
      output rx_data, rx_valid,
      input  addr, shift, en, err, err_code
   );
endinterface

// File: rtl/cfg_timer.sv
// Inter-byte timeout counter; expired is a combinational strobe for the edge that reaches TIMEOUT.
module cfg_timer #(
   parameter int unsigned TIMEOUT = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic kick,
   output logic expired
);
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!run || kick) begin
         cnt_d = '0;
      end else if (cnt_q != CW'(TIMEOUT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // A byte on the same edge wins over the timeout.
   assign expired = run && !kick && (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/cfg_writer.sv
// Parses SYNC/ADDR/DATA/CSUM frames from the UART byte stream and drives the parameter write bus.
module cfg_writer
   import cfg_pkg::*;
#(
   parameter int unsigned DATA_MAX = 255,
   parameter int unsigned ADDR_MAX = 4,
   parameter int unsigned TIMEOUT  = 50000
) (
   input  logic            clk,
   input  logic            rst_n,
   cfg_writer_if.master    bus
);
   localparam int unsigned DW   = $clog2(DATA_MAX + 1);
   localparam int unsigned AW   = $clog2(ADDR_MAX + 1);
   localparam int unsigned NB   = (DW + 7) / 8;
   localparam int unsigned AccW = 8 * NB;
   localparam int unsigned CntW = (NB > 1) ? $clog2(NB) : 1;

   state_e          state_q, state_d;
   logic [7:0]      addr_byte_q, addr_byte_d;
   logic [7:0]      csum_q, csum_d;
   logic [AccW-1:0] acc_q, acc_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   shift_q, shift_d;
   logic            en_q, en_d;
   logic            err_q, err_d;
   err_code_e       err_code_q, err_code_d;
   logic            timeout;

   cfg_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (state_q != IDLE),
      .kick    (bus.rx_valid),
      .expired (timeout)
   );

   always_comb begin
      state_d     = state_q;
      addr_byte_d = addr_byte_q;
      csum_d      = csum_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      shift_d     = shift_q;
      en_d        = 1'b0;
      err_d       = 1'b0;
      err_code_d  = err_code_q;

      if (timeout) begin
         state_d    = IDLE;
         err_d      = 1'b1;
         err_code_d = ERR_TIMEOUT;
      end else if (bus.rx_valid) begin
         unique case (state_q)
            IDLE: begin
               if (bus.rx_data == SYNC_BYTE) state_d = ADDR;
            end
            ADDR: begin
               addr_byte_d = bus.rx_data;
               csum_d      = bus.rx_data;
               acc_d       = '0;
               cnt_d       = '0;
               state_d     = DATA;
            end
            DATA: begin
               // Little-endian placement: byte k lands at bits [8k+7:8k].
               acc_d  = acc_q | (AccW'(bus.rx_data) << {cnt_q, 3'b000});
               csum_d = csum_q ^ bus.rx_data;
               if (cnt_q == CntW'(NB - 1)) begin
                  state_d = CSUM;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            CSUM: begin
               state_d = IDLE;
               if (bus.rx_data != csum_q) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_CSUM;
               end else if ((addr_byte_q > 8'(ADDR_MAX)) || (acc_q > AccW'(DATA_MAX))) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_RANGE;
               end else begin
                  addr_d  = addr_byte_q[AW-1:0];
                  shift_d = acc_q[DW-1:0];
                  en_d    = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_byte_q <= '0;
         csum_q      <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         addr_q      <= '0;
         shift_q     <= '0;
         en_q        <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         state_q     <= state_d;
         addr_byte_q <= addr_byte_d;
         csum_q      <= csum_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         shift_q     <= shift_d;
         en_q        <= en_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
      end
   end

   assign bus.addr     = addr_q;
   assign bus.shift    = shift_q;
   assign bus.en       = en_q;
   assign bus.err      = err_q;
   assign bus.err_code = err_code_q;
endmodule

// File: tb/tb_cfg_writer.sv
// Directed bench: default instance, DATA_MAX=1000 instance and TIMEOUT=20 instance.
module tb_cfg_writer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   cfg_writer_if #(.AW(3), .DW(8))  bus0 ();
   cfg_writer_if #(.AW(3), .DW(10)) bus1 ();
   cfg_writer_if #(.AW(3), .DW(8))  bus2 ();

   cfg_writer u_dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   cfg_writer #(.DATA_MAX(1000)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   cfg_writer #(.TIMEOUT(20)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Byte is held valid across exactly one rising edge; returns 1 time unit after that edge.
   task automatic send(input int sel, input logic [7:0] b);
      case (sel)
         0: begin bus0.rx_data = b; bus0.rx_valid = 1'b1; end
         1: begin bus1.rx_data = b; bus1.rx_valid = 1'b1; end
         default: begin bus2.rx_data = b; bus2.rx_valid = 1'b1; end
      endcase
      @(posedge clk);
      #1;
      bus0.rx_valid = 1'b0;
      bus1.rx_valid = 1'b0;
      bus2.rx_valid = 1'b0;
   endtask

   task automatic send4(input int sel, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
      send(sel, a);
      send(sel, b);
      send(sel, c);
      send(sel, d);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus0.rx_data = 8'h00; bus0.rx_valid = 1'b0;
      bus1.rx_data = 8'h00; bus1.rx_valid = 1'b0;
      bus2.rx_data = 8'h00; bus2.rx_valid = 1'b0;

      #3;
      chk("rst_addr", 32'(bus0.addr), 0);
      chk("rst_shift", 32'(bus0.shift), 0);
      chk("rst_en", 32'(bus0.en), 0);
      chk("rst_err", 32'(bus0.err), 0);
      chk("rst_err_code", 32'(bus0.err_code), 0);
      chk("rst_shift_wide", 32'(bus1.shift), 0);
      #9 rst_n = 1'b1;
      tick();

      // Single write and hold.
      send4(0, 8'hA5, 8'h04, 8'h37, 8'h33);
      chk("wr1_en", 32'(bus0.en), 1);
      chk("wr1_addr", 32'(bus0.addr), 4);
      chk("wr1_shift", 32'(bus0.shift), 32'h37);
      chk("wr1_err", 32'(bus0.err), 0);
      tick();
      chk("wr1_en_drop", 32'(bus0.en), 0);
      chk("wr1_addr_hold", 32'(bus0.addr), 4);
      chk("wr1_shift_hold", 32'(bus0.shift), 32'h37);

      // Bad checksum, then recovery.
      send4(0, 8'hA5, 8'h02, 8'h10, 8'h13);
      chk("csum_err", 32'(bus0.err), 1);
      chk("csum_code", 32'(bus0.err_code), 1);
      chk("csum_no_en", 32'(bus0.en), 0);
      chk("csum_addr_kept", 32'(bus0.addr), 4);
      chk("csum_shift_kept", 32'(bus0.shift), 32'h37);
      tick();
      chk("csum_err_drop", 32'(bus0.err), 0);
      chk("csum_code_hold", 32'(bus0.err_code), 1);
      send4(0, 8'hA5, 8'h02, 8'h10, 8'h12);
      chk("rec_en", 32'(bus0.en), 1);
      chk("rec_addr", 32'(bus0.addr), 2);
      chk("rec_shift", 32'(bus0.shift), 32'h10);

      // Asynchronous reset mid-frame.
      send(0, 8'hA5);
      send(0, 8'h01);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_addr", 32'(bus0.addr), 0);
      chk("arst_shift", 32'(bus0.shift), 0);
      chk("arst_code", 32'(bus0.err_code), 0);
      chk("arst_en", 32'(bus0.en), 0);
      #3 rst_n = 1'b1;
      tick();
      send(0, 8'h7F);
      chk("tail1_en", 32'(bus0.en), 0);
      chk("tail1_err", 32'(bus0.err), 0);
      send(0, 8'h7E);
      chk("tail2_en", 32'(bus0.en), 0);
      chk("tail2_err", 32'(bus0.err), 0);
      tick();
      chk("tail3_en", 32'(bus0.en), 0);
      chk("tail3_err", 32'(bus0.err), 0);

      // Address out of range.
      send4(0, 8'hA5, 8'h05, 8'h01, 8'h04);
      chk("range_err", 32'(bus0.err), 1);
      chk("range_code", 32'(bus0.err_code), 2);
      chk("range_no_en", 32'(bus0.en), 0);

      // Noise, payload 0xA5, back-to-back frames.
      send(0, 8'h00);
      send(0, 8'hFF);
      chk("noise_en", 32'(bus0.en), 0);
      send4(0, 8'hA5, 8'h03, 8'hA5, 8'hA6);
      chk("b2b1_en", 32'(bus0.en), 1);
      chk("b2b1_addr", 32'(bus0.addr), 3);
      chk("b2b1_shift", 32'(bus0.shift), 32'hA5);
      send(0, 8'hA5);
      chk("b2b1_en_drop", 32'(bus0.en), 0);
      send(0, 8'h00);
      send(0, 8'h00);
      send(0, 8'h00);
      chk("b2b2_en", 32'(bus0.en), 1);
      chk("b2b2_addr", 32'(bus0.addr), 0);
      chk("b2b2_shift", 32'(bus0.shift), 0);
      chk("b2b2_code_hold", 32'(bus0.err_code), 2);

      // Two-byte data: 1001 rejected, 1000 accepted.
      send4(1, 8'hA5, 8'h01, 8'hE9, 8'h03);
      send(1, 8'hEB);
      chk("wide_range_err", 32'(bus1.err), 1);
      chk("wide_range_code", 32'(bus1.err_code), 2);
      chk("wide_range_no_en", 32'(bus1.en), 0);
      send4(1, 8'hA5, 8'h01, 8'hE8, 8'h03);
      send(1, 8'hEA);
      chk("wide_en", 32'(bus1.en), 1);
      chk("wide_addr", 32'(bus1.addr), 1);
      chk("wide_shift", 32'(bus1.shift), 1000);

      // Timeout 20 clocks after the last accepted byte.
      send(2, 8'hA5);
      send(2, 8'h01);
      repeat (19) @(posedge clk);
      #1;
      chk("to_before", 32'(bus2.err), 0);
      tick();
      chk("to_err", 32'(bus2.err), 1);
      chk("to_code", 32'(bus2.err_code), 3);
      chk("to_no_en", 32'(bus2.en), 0);
      tick();
      chk("to_err_drop", 32'(bus2.err), 0);
      send4(2, 8'hA5, 8'h01, 8'h05, 8'h04);
      chk("to_rec_en", 32'(bus2.en), 1);
      chk("to_rec_shift", 32'(bus2.shift), 5);

      // Byte arriving on the 20th clock keeps the frame alive.
      send(2, 8'hA5);
      send(2, 8'h01);
      repeat (19) @(posedge clk);
      #1;
      send(2, 8'h07);
      chk("to_edge_err", 32'(bus2.err), 0);
      send(2, 8'h06);
      chk("to_edge_en", 32'(bus2.en), 1);
      chk("to_edge_addr", 32'(bus2.addr), 1);
      chk("to_edge_shift", 32'(bus2.shift), 7);
      chk("to_edge_err2", 32'(bus2.err), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
